// File: rtl/seq_shifter.sv
// seq_shifter: iterative shift/rotate unit, one bit position per clock.
// Request accepted on in_valid & in_ready, result presented on out_valid
// and held until out_ready. Supports SHL/SHR/SAR/ROL/ROR with a multi-bit
// step count; counts >= WIDTH are executed literally, step by step.
module seq_shifter #(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       cmd,
    input  logic [AMT_W-1:0] amt,
    input  logic [WIDTH-1:0] data_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero
);

    localparam logic [2:0] CMD_NONE = 3'd0;
    localparam logic [2:0] CMD_SHL  = 3'd1;
    localparam logic [2:0] CMD_SHR  = 3'd2;
    localparam logic [2:0] CMD_ROL  = 3'd3;
    localparam logic [2:0] CMD_ROR  = 3'd4;
    localparam logic [2:0] CMD_SAR  = 3'd5;

    localparam logic [AMT_W-1:0] CNT_ZERO = {AMT_W{1'b0}};
    localparam logic [AMT_W-1:0] CNT_ONE  = {{(AMT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [AMT_W-1:0]   cnt_r;
    logic [AMT_W-1:0]   cnt_nxt_s;
    logic [2:0]         cmd_r;
    logic [2:0]         cmd_nxt_s;
    logic [WIDTH-1:0]   result_r;
    logic [WIDTH-1:0]   result_nxt_s;
    logic               carry_r;
    logic               carry_nxt_s;
    logic               zero_r;
    logic               out_valid_r;
    logic               out_valid_nxt_s;
    logic               in_ready_r;
    logic               in_ready_nxt_s;
    logic               accept_s;
    logic               is_noop_s;
    logic               last_step_s;
    logic [WIDTH:0]     step_s;

    // One single-bit step: returns {carry_out, new_value}.
    function automatic logic [WIDTH:0] step_f(input logic [2:0] op,
                                              input logic [WIDTH-1:0] r);
        logic [WIDTH:0] res;
        case (op)
            CMD_SHL: res = {r[WIDTH-1], r[WIDTH-2:0], 1'b0};
            CMD_SHR: res = {r[0], 1'b0, r[WIDTH-1:1]};
            CMD_SAR: res = {r[0], r[WIDTH-1], r[WIDTH-1:1]};
            CMD_ROL: res = {r[WIDTH-1], r[WIDTH-2:0], r[WIDTH-1]};
            CMD_ROR: res = {r[0], r[0], r[WIDTH-1:1]};
            default: res = {1'b0, r};
        endcase
        return res;
    endfunction

    assign accept_s    = (state_r == ST_IDLE) && in_valid;
    assign is_noop_s   = (cmd == CMD_NONE) || (cmd > CMD_SAR) || (amt == CNT_ZERO);
    assign last_step_s = (state_r == ST_SHIFT) && (cnt_r == CNT_ONE);
    assign step_s      = step_f(cmd_r, result_r);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: IDLE -> SHIFT/DONE on accept, SHIFT -> DONE on last step,
    // DONE -> IDLE once the presented result has been taken.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (is_noop_s) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_SHIFT;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (cnt_r == CNT_ONE) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_SHIFT;
                end
            end
            ST_DONE: begin
                if (out_valid_r && out_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Handshake outputs, computed one cycle ahead so they can be registered.
    // out_valid rises with the final step, or one cycle after entering DONE
    // directly, giving a latency of max(amt,1) edges.
    always_comb begin
        in_ready_nxt_s  = (state_nxt_s == ST_IDLE);
        out_valid_nxt_s = 1'b0;
        if (out_valid_r) begin
            out_valid_nxt_s = !out_ready;
        end else if (last_step_s || (state_r == ST_DONE)) begin
            out_valid_nxt_s = 1'b1;
        end else begin
            out_valid_nxt_s = 1'b0;
        end
    end

    // Datapath next values: latch operands on accept, step while shifting, hold otherwise.
    always_comb begin
        result_nxt_s = result_r;
        carry_nxt_s  = carry_r;
        cnt_nxt_s    = cnt_r;
        cmd_nxt_s    = cmd_r;
        if (accept_s) begin
            result_nxt_s = data_in;
            carry_nxt_s  = 1'b0;
            cmd_nxt_s    = cmd;
            if (is_noop_s) begin
                cnt_nxt_s = CNT_ZERO;
            end else begin
                cnt_nxt_s = amt;
            end
        end else if (state_r == ST_SHIFT) begin
            result_nxt_s = step_s[WIDTH-1:0];
            carry_nxt_s  = step_s[WIDTH];
            cnt_nxt_s    = cnt_r - CNT_ONE;
        end else begin
            result_nxt_s = result_r;
            carry_nxt_s  = carry_r;
        end
    end

    // Datapath and handshake registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            result_r    <= {WIDTH{1'b0}};
            carry_r     <= 1'b0;
            cnt_r       <= CNT_ZERO;
            cmd_r       <= CMD_NONE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            result_r    <= result_nxt_s;
            carry_r     <= carry_nxt_s;
            cnt_r       <= cnt_nxt_s;
            cmd_r       <= cmd_nxt_s;
            out_valid_r <= out_valid_nxt_s;
            in_ready_r  <= in_ready_nxt_s;
        end
    end

    // Zero flag captured as the result is first presented; held while waiting.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            zero_r <= 1'b0;
        end else if (out_valid_nxt_s && !out_valid_r) begin
            zero_r <= (result_nxt_s == {WIDTH{1'b0}});
        end else begin
            zero_r <= zero_r;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign carry     = carry_r;
    assign zero      = zero_r;

endmodule

// File: tb/tb_seq_shifter.sv
// Self-checking bench for seq_shifter (WIDTH=8): directed cases plus random
// operations compared against an arithmetic reference model.
module tb_seq_shifter;

    localparam int W  = 8;
    localparam int AW = 4;

    logic          clk;
    logic          reset_n;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    cmd;
    logic [AW-1:0] amt;
    logic [W-1:0]  data_in;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;
    logic          carry;
    logic          zero;

    int total = 0;
    int bad   = 0;

    seq_shifter #(.WIDTH(W), .AMT_W(AW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .cmd       (cmd),
        .amt       (amt),
        .data_in   (data_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry     (carry),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: whole-operation result from plain shift arithmetic on a wide value.
    function automatic void model(input int c, input int n, input logic [W-1:0] d,
                                  output logic [W-1:0] r, output logic cy);
        logic [63:0]        u;
        logic [63:0]        t;
        logic signed [63:0] s;
        logic signed [63:0] st;
        int                 k;
        u = 64'(d);
        s = {{(64-W){d[W-1]}}, d};
        k = n % W;
        case (c)
            1: begin t = u << n; r = t[W-1:0]; t = t >> W; cy = t[0]; end
            2: begin t = u >> n; r = t[W-1:0]; t = (u << 1) >> n; cy = t[0]; end
            5: begin st = s >>> n; r = st[W-1:0]; st = (s <<< 1) >>> n; cy = st[0]; end
            3: begin
                t = (u << k) | (u >> (W - k)); r = t[W-1:0];
                cy = (n == 0) ? 1'b0 : r[0];
            end
            4: begin
                t = (u >> k) | (u << (W - k)); r = t[W-1:0];
                cy = (n == 0) ? 1'b0 : r[W-1];
            end
            default: begin r = d; cy = 1'b0; end
        endcase
    endfunction

    // Issue one request with out_ready high and check latency, result and flags.
    task automatic run_op(input logic [2:0] c, input logic [AW-1:0] n, input logic [W-1:0] d);
        logic [W-1:0] er;
        logic         ec;
        int           edges;
        int           explat;
        model(int'(c), int'(n), d, er, ec);
        explat = (n == 0 || c == 3'd0 || c > 3'd5) ? 1 : int'(n);
        chk("pre_in_ready", 32'(in_ready), 32'd1);
        cmd = c; amt = n; data_in = d; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cmd = 3'($urandom); amt = AW'($urandom); data_in = W'($urandom);
        edges = 0;
        while (out_valid !== 1'b1 && edges < 40) begin
            @(posedge clk); #1;
            edges++;
        end
        chk($sformatf("latency c%0d n%0d", c, n), 32'(edges), 32'(explat));
        chk($sformatf("result c%0d n%0d d%0h", c, n, d), 32'(result), 32'(er));
        chk($sformatf("carry c%0d n%0d d%0h", c, n, d), 32'(carry), 32'(ec));
        chk("zero", 32'(zero), 32'(er == '0));
        @(posedge clk); #1;
        chk("post_out_valid", 32'(out_valid), 32'd0);
        chk("post_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin : main
        logic [W-1:0] er;
        logic         ec;
        int           edges;
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        cmd = 3'd0; amt = '0; data_in = '0;
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_carry", 32'(carry), 32'd0);
        chk("rst_zero", 32'(zero), 32'd0);
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases from the plan, each also checked against the model.
        run_op(3'd1, 4'd1, 8'h81);
        chk("shl81_val", 32'(result), 32'h02);
        run_op(3'd5, 4'd3, 8'h80);
        chk("sar80_val", 32'(result), 32'hF0);
        run_op(3'd2, 4'd3, 8'h80);
        chk("shr80_val", 32'(result), 32'h10);
        run_op(3'd4, 4'd1, 8'h01);
        chk("ror01_val", 32'(result), 32'h80);
        chk("ror01_cy", 32'(carry), 32'd1);
        run_op(3'd3, 4'd8, 8'h96);
        chk("rol96_val", 32'(result), 32'h96);
        run_op(3'd2, 4'd8, 8'hFF);
        chk("shrff8_cy", 32'(carry), 32'd1);
        run_op(3'd2, 4'd9, 8'hFF);
        chk("shrff9_cy", 32'(carry), 32'd0);
        run_op(3'd1, 4'd15, 8'hFF);
        run_op(3'd5, 4'd12, 8'h80);
        run_op(3'd0, 4'd5, 8'h5A);
        chk("none_val", 32'(result), 32'h5A);
        run_op(3'd7, 4'd5, 8'h5A);
        run_op(3'd6, 4'd3, 8'hC3);
        run_op(3'd1, 4'd0, 8'hC3);

        // Backpressure: result held, extra request ignored.
        out_ready = 1'b0;
        cmd = 3'd2; amt = 4'd2; data_in = 8'hA5; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        model(2, 2, 8'hA5, er, ec);
        edges = 0;
        while (out_valid !== 1'b1 && edges < 40) begin
            @(posedge clk); #1;
            edges++;
        end
        chk("bp_latency", 32'(edges), 32'd2);
        for (int i = 0; i < 3; i++) begin
            cmd = 3'd1; amt = 4'd1; data_in = 8'h3C; in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_result", 32'(result), 32'(er));
            chk("bp_carry", 32'(carry), 32'(ec));
            chk("bp_zero", 32'(zero), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", 32'(out_valid), 32'd0);
        chk("bp_release_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("bp_no_extra", 32'(out_valid), 32'd0);
        end

        // Reset pulse mid-shift aborts the operation.
        cmd = 3'd1; amt = 4'd12; data_in = 8'hFF; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_result", 32'(result), 32'd0);
        @(negedge clk); reset_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            chk("abort_quiet", 32'(out_valid), 32'd0);
        end
        chk("abort_in_ready_after", 32'(in_ready), 32'd1);

        // Random operations against the model.
        for (int i = 0; i < 25; i++) begin
            run_op(3'($urandom_range(0, 7)), AW'($urandom_range(0, 15)), W'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
